// File: rtl/nes_clk_gen.sv
// NES clock-enable generator: turns the master clock into CPU/PPU/APU strobes (NTSC/PAL) with pause.
// Define NES_CLKGEN_STEP_EN to build the STEP state; otherwise step is ignored.
`timescale 1ns/1ps
module nes_clk_gen #(
    parameter int CPU_DIV_NTSC = 12,
    parameter int PPU_DIV_NTSC = 4,
    parameter int CPU_DIV_PAL  = 16,
    parameter int PPU_DIV_PAL  = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pal,
    input  logic        pause_req,
    output logic        pause_ack,
    input  logic        step,
    output logic        cpu_ce,
    output logic        ppu_ce,
    output logic        apu_ce,
    output logic        pal_active,
    output logic [15:0] cpu_cycle
);
    localparam int CPU_MAX = (CPU_DIV_NTSC > CPU_DIV_PAL) ? CPU_DIV_NTSC : CPU_DIV_PAL;
    localparam int PPU_MAX = (PPU_DIV_NTSC > PPU_DIV_PAL) ? PPU_DIV_NTSC : PPU_DIV_PAL;
    localparam int MW = $clog2(CPU_MAX);
    localparam int PW = $clog2(PPU_MAX);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1
`ifdef NES_CLKGEN_STEP_EN
        , STEP = 2'd2
`endif
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [MW-1:0] m;
    logic [MW-1:0] cpu_last;
    logic [PW-1:0] p;
    logic [PW-1:0] ppu_last;
    logic          parity;
    logic          first;
    logic          advance;
    logic          cpu_hit;
    logic          ppu_hit;
    logic          region_change;
    logic          restart;

`ifndef NES_CLKGEN_STEP_EN
    logic unused_step;
    assign unused_step = step;
`endif

    // Strobes are decided from the current counts and registered on the same edge.
    always_comb begin
        cpu_last      = pal_active ? MW'(CPU_DIV_PAL - 1) : MW'(CPU_DIV_NTSC - 1);
        ppu_last      = pal_active ? PW'(PPU_DIV_PAL - 1) : PW'(PPU_DIV_NTSC - 1);
        advance       = (state != PAUSED);
        cpu_hit       = advance && (m == cpu_last);
        ppu_hit       = advance && (p == ppu_last);
        region_change = cpu_hit && (pal != pal_active);
        next_state    = state;
        case (state)
            RUN:    if (cpu_hit && pause_req) next_state = PAUSED;
            PAUSED: begin
                if (!pause_req) next_state = RUN;
`ifdef NES_CLKGEN_STEP_EN
                else if (step) next_state = STEP;
`endif
            end
`ifdef NES_CLKGEN_STEP_EN
            STEP:   if (cpu_hit) next_state = PAUSED;
`endif
            default: next_state = RUN;
        endcase
        restart = cpu_hit && (region_change || (next_state == PAUSED));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            m          <= '0;
            p          <= '0;
            parity     <= 1'b0;
            first      <= 1'b1;
            pal_active <= 1'b0;
            cpu_cycle  <= '0;
            cpu_ce     <= 1'b0;
            ppu_ce     <= 1'b0;
            apu_ce     <= 1'b0;
            pause_ack  <= 1'b0;
        end else begin
            state     <= next_state;
            pause_ack <= (state == PAUSED) && (next_state == PAUSED);
            cpu_ce    <= cpu_hit;
            ppu_ce    <= ppu_hit;
            apu_ce    <= cpu_hit && parity;
            if (cpu_hit) begin
                parity    <= ~parity;
                cpu_cycle <= cpu_cycle + 16'd1;
            end
            // Leaving reset is a CPU boundary, so the region is picked up on the first edge.
            first <= 1'b0;
            if (first || region_change) pal_active <= pal;
            if (advance) begin
                m <= cpu_hit ? '0 : m + MW'(1);
                p <= (ppu_hit || restart) ? '0 : p + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_nes_clk_gen.sv
// Directed bench for nes_clk_gen: strobe positions per cycle index, pause/resume, step, region change, reset.
`timescale 1ns/1ps
module tb_nes_clk_gen;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pal = 1'b0;
    logic        pause_req = 1'b0;
    logic        step = 1'b0;
    logic        pause_ack;
    logic        cpu_ce;
    logic        ppu_ce;
    logic        apu_ce;
    logic        pal_active;
    logic [15:0] cpu_cycle;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc    = -1;
    logic [255:0] cpu_m, ppu_m, apu_m, ack_m, pala_m;

    always #5 clk = ~clk;

    nes_clk_gen dut (
        .clk        (clk),
        .reset      (reset),
        .pal        (pal),
        .pause_req  (pause_req),
        .pause_ack  (pause_ack),
        .step       (step),
        .cpu_ce     (cpu_ce),
        .ppu_ce     (ppu_ce),
        .apu_ce     (apu_ce),
        .pal_active (pal_active),
        .cpu_cycle  (cpu_cycle)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] seq(input int first, input int stride, input int last);
        logic [255:0] v;
        v = '0;
        for (int k = first; k <= last; k += stride) v[k] = 1'b1;
        return v;
    endfunction

    task automatic clear_masks();
        cpu_m = '0; ppu_m = '0; apu_m = '0; ack_m = '0; pala_m = '0;
    endtask

    // Cycle n is sampled 1 ns after the n-th rising edge following reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cpu_ce)     cpu_m[cyc]  = 1'b1;
        if (ppu_ce)     ppu_m[cyc]  = 1'b1;
        if (apu_ce)     apu_m[cyc]  = 1'b1;
        if (pause_ack)  ack_m[cyc]  = 1'b1;
        if (pal_active) pala_m[cyc] = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = -1;
        clear_masks();
    endtask

    function automatic logic [255:0] outs();
        return {235'd0, cpu_ce, ppu_ce, apu_ce, pause_ack, pal_active, cpu_cycle};
    endfunction

    initial begin
        // NTSC free run
        pal = 1'b0;
        do_reset();
        chk("reset_outputs_ntsc", outs(), '0);
        for (int i = 0; i < 48; i++) tick();
        chk("ntsc_cpu_ce", cpu_m, seq(11, 12, 47));
        chk("ntsc_ppu_ce", ppu_m, seq(3, 4, 47));
        chk("ntsc_ppu_count", 256'($countones(ppu_m)), 256'd12);
        chk("ntsc_apu_ce", apu_m, seq(23, 24, 47));
        chk("ntsc_cpu_cycle", 256'(cpu_cycle), 256'd4);
        chk("ntsc_pal_active", pala_m, '0);
        chk("ntsc_no_ack", ack_m, '0);

        // PAL from reset
        pal = 1'b1;
        do_reset();
        chk("reset_outputs_pal", outs(), '0);
        for (int i = 0; i < 80; i++) tick();
        chk("pal_cpu_ce", cpu_m, seq(15, 16, 79));
        chk("pal_ppu_ce", ppu_m, seq(4, 5, 79));
        chk("pal_ppu_count", 256'($countones(ppu_m)), 256'd16);
        chk("pal_apu_ce", apu_m, seq(31, 32, 79));
        chk("pal_active_on", pala_m, seq(0, 1, 79));
        chk("pal_cpu_cycle", 256'(cpu_cycle), 256'd5);

        // Pause raised at cycle 14, dropped at cycle 40
        pal = 1'b0;
        do_reset();
        for (int i = 0; i <= 60; i++) begin
            tick();
            if (cyc == 13) pause_req = 1'b1;
            if (cyc == 39) pause_req = 1'b0;
        end
        chk("pause_cpu_ce", cpu_m, seq(11, 12, 23) | seq(52, 1, 52));
        chk("pause_ppu_ce", ppu_m, seq(3, 4, 23) | seq(44, 4, 60));
        chk("pause_apu_ce", apu_m, seq(23, 1, 23));
        chk("pause_ack", ack_m, seq(24, 1, 39));
        chk("pause_cpu_cycle", 256'(cpu_cycle), 256'd3);

        // Paused from reset, step pulses at edges 21, 26 (inside STEP) and 56
        pause_req = 1'b1;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            tick();
            if (cyc == 20 || cyc == 25 || cyc == 55) step = 1'b1;
            if (cyc == 21 || cyc == 26 || cyc == 56) step = 1'b0;
        end
`ifdef NES_CLKGEN_STEP_EN
        chk("step_cpu_ce", cpu_m, seq(11, 1, 11) | seq(33, 1, 33));
        chk("step_ppu_ce", ppu_m, seq(3, 4, 11) | seq(25, 4, 33));
        chk("step_apu_ce", apu_m, seq(33, 1, 33));
        chk("step_ack", ack_m, seq(12, 1, 20) | seq(34, 1, 55));
        chk("step_cpu_cycle", 256'(cpu_cycle), 256'd2);
`else
        chk("step_cpu_ce", cpu_m, seq(11, 1, 11));
        chk("step_ppu_ce", ppu_m, seq(3, 4, 11));
        chk("step_apu_ce", apu_m, '0);
        chk("step_ack", ack_m, seq(12, 1, 59));
        chk("step_cpu_cycle", 256'(cpu_cycle), 256'd1);
`endif
        // Asynchronous reset mid-operation, between edges
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", outs(), '0);
        pause_req = 1'b0;
        step = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = -1;
        clear_masks();
        for (int i = 0; i < 13; i++) tick();
        chk("after_reset_cpu_ce", cpu_m, seq(11, 1, 11));
        chk("after_reset_ack", ack_m, '0);
        chk("after_reset_cpu_cycle", 256'(cpu_cycle), 256'd1);

        // Region toggle mid-CPU-cycle at cycle 5
        pal = 1'b0;
        do_reset();
        for (int i = 0; i <= 60; i++) begin
            tick();
            if (cyc == 4) pal = 1'b1;
        end
        chk("region_cpu_ce", cpu_m, seq(11, 1, 11) | seq(27, 16, 59));
        chk("region_ppu_ce", ppu_m, seq(3, 4, 11) | seq(16, 5, 56));
        chk("region_apu_ce", apu_m, seq(27, 32, 59));
        chk("region_pal_active", pala_m, seq(11, 1, 60));
        chk("region_cpu_cycle", 256'(cpu_cycle), 256'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
